clk_div_bank: RTL and testbench
===============================

# clk_div_bank

Parametrised, multi-channel successor to the single-counter frequency divider. It generates N independent clock-enable ticks and 50%-duty divided square waves from one global clock. Each channel has a divisor that can be written at run time, with glitch-free reload at wrap. It also drives a SCAN_BITS-wide scan-select counter for display multiplexing. It sits at the top of each lab design and feeds 7-segment scan logic, debouncers and slow state machines.

## Interface
- N_CH, 4, number of divider channels (1..16)
- CNT_W, 25, width of each channel's counter and divisor
- SCAN_BITS, 2, width of scan_ctl
- SCAN_CH, 0, channel whose tick advances scan_ctl
- DEFAULT_DIV, 2**CNT_W-1, divisor loaded into every channel at reset
- clk  in  1  global clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- en  in  N_CH  per-channel run enable
- div_wr  in  1  one-cycle divisor write strobe
- div_sel  in  $clog2(N_CH) (min 1)  channel addressed by div_wr
- div_val  in  CNT_W  new divisor
- tick  out  N_CH  registered one-cycle pulse per channel period
- clk_out  out  N_CH  registered divided clock; toggles on each tick
- scan_ctl  out  SCAN_BITS  registered scan counter

## Operation
- Per channel: active divisor `act`, pending divisor `pend`, pending flag `pv`, counter `cnt`.
- Effective limit: `lim = (act <= 1) ? 0 : act - 1`. The tick period is max(act, 1) cycles. clk_out period is 2·max(act, 1) cycles.
- Enabled channel, each cycle:
  - If `cnt == lim`: `cnt <= 0`, `tick <= 1`, `clk_out <= ~clk_out`. If `pv` is set, `act <= pend` and `pv <= 0`.
  - Otherwise: `cnt <= cnt + 1` and `tick <= 0`.
- Disabled channel (`en[i] = 0`):
  - `cnt <= 0`, `tick <= 0`, `clk_out <= 0`.
  - A pending divisor is applied immediately: `act <= pend`, `pv <= 0`.
- Re-enable: the first tick comes `lim + 1` cycles after the first enabled edge.
- Write (`div_wr = 1`, `div_sel < N_CH`): `pend <= div_val`, `pv <= 1`. A later write before the wrap overwrites `pend` (last write wins).
- Writes with `div_sel >= N_CH` are ignored.
- Write on the same edge as a wrap: `act` is loaded directly with `div_val` and `pv` stays 0. The current wrap still uses the old `lim`.
- Write to a disabled channel: the value becomes `act` on the next edge.
- scan_ctl increments (mod 2**SCAN_BITS) on every edge where `tick[SCAN_CH]` is 1. scan_ctl therefore lags the tick by one cycle.
- All arithmetic is unsigned CNT_W bits. The counter never exceeds `lim`, so there is no overflow path.

## Timing
- Reset (async assert, sync release) values:
  - `cnt = 0`, `act = DEFAULT_DIV`, `pend = 0`, `pv = 0`
  - `tick = 0`, `clk_out = 0`, `scan_ctl = 0`
- All outputs are flop outputs; there is no combinational path from inputs to outputs.
- Latency, assuming `en` was high at the enabled edge and no write is pending:
  - tick asserts on edge k·max(act, 1) after the enabled edge.
  - The first tick appears on edge `lim + 1`.
- With `act ≤ 1`, tick stays high continuously and clk_out toggles every cycle.
- Reset asserted mid-period: all state clears asynchronously. No partial tick is emitted after release.
- Channels are fully independent. Simultaneous ticks on several channels are legal.

## Structure
- Package `clk_div_pkg` holds:
  - the defaults N_CH_DEF, CNT_W_DEF, SCAN_BITS_DEF
  - the helper function `sel_w(n)`, which returns max(1, $clog2(n))
- Sub-module `clk_div_chan`: one channel, holding cnt, act, pend, pv, tick and clk_out.
  - Ports: clk, rst, en, wr, val, tick, clk_out.
- The top instantiates `clk_div_chan` N_CH times with a generate loop, decodes `div_sel` into per-channel `wr`, and owns the scan_ctl register.

## Test plan
- Reset with CNT_W=4 and DEFAULT_DIV=15, then en=4'b0001 → tick[0] on edges 15, 30, 45. clk_out[0] is high for 15 cycles and low for 15. scan_ctl reads 1, 2, 3, 0 after successive ticks.
- Channel 1 running with act=6; write div_val=3 at cycle 2 of the period → the next tick still arrives at cycle 6, then ticks follow every 3 cycles.
- Write coincident with a wrap (act=5, write 2 on the wrap edge) → that tick fires, the next tick comes 2 cycles later, and pv is never set.
- Write div_val=0 and then div_val=1 to channel 2 → tick[2] is held at 1 every cycle and clk_out[2] toggles every cycle.
- Drop en[3] mid-period, write 4, then raise en[3] → while disabled, cnt=0, tick=0, clk_out=0. The first tick comes 4 cycles after re-enable.
- Assert rst asynchronously mid-period with all channels running → all outputs go to 0 before the next clk edge. A write with div_sel=N_CH has no effect.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the clock-divider bank.
package clk_div_pkg;

    localparam int unsigned N_CH_DEF      = 4;
    localparam int unsigned CNT_W_DEF     = 25;
    localparam int unsigned SCAN_BITS_DEF = 2;

    // Select-bus width for n channels, never narrower than one bit.
    function automatic int unsigned sel_w(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: tick pulse and 50% divided clock, with reload at wrap.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned      CNT_W       = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] val,
    output logic             tick,
    output logic             clk_out
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_act;
    logic [CNT_W-1:0] r_pend;
    logic             r_pv;
    logic             r_tick;
    logic             r_clk;

    logic [CNT_W-1:0] w_lim;
    logic             w_wrap;

    // Divisors 0 and 1 both collapse to a tick on every cycle.
    always_comb begin
        w_lim  = (r_act <= CNT_W'(1)) ? '0 : r_act - CNT_W'(1);
        w_wrap = (r_cnt == w_lim);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_act  <= DEFAULT_DIV;
            r_pend <= '0;
            r_pv   <= 1'b0;
            r_tick <= 1'b0;
            r_clk  <= 1'b0;
        end else if (!en) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
            r_clk  <= 1'b0;
            if (wr) begin
                r_act  <= val;
                r_pend <= val;
                r_pv   <= 1'b0;
            end else if (r_pv) begin
                r_act <= r_pend;
                r_pv  <= 1'b0;
            end
        end else if (w_wrap) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
            r_clk  <= ~r_clk;
            // A write landing on the wrap edge bypasses the pending stage.
            if (wr) begin
                r_act  <= val;
                r_pend <= val;
                r_pv   <= 1'b0;
            end else if (r_pv) begin
                r_act <= r_pend;
                r_pv  <= 1'b0;
            end
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_tick <= 1'b0;
            if (wr) begin
                r_pend <= val;
                r_pv   <= 1'b1;
            end
        end
    end

    assign tick    = r_tick;
    assign clk_out = r_clk;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent clock dividers plus a display scan-select counter.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int unsigned      N_CH        = N_CH_DEF,
    parameter int unsigned      CNT_W       = CNT_W_DEF,
    parameter int unsigned      SCAN_BITS   = SCAN_BITS_DEF,
    parameter int unsigned      SCAN_CH     = 0,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = '1,
    localparam int unsigned     SEL_W       = sel_w(N_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH-1:0]      en,
    input  logic                 div_wr,
    input  logic [SEL_W-1:0]     div_sel,
    input  logic [CNT_W-1:0]     div_val,
    output logic [N_CH-1:0]      tick,
    output logic [N_CH-1:0]      clk_out,
    output logic [SCAN_BITS-1:0] scan_ctl
);

    logic [N_CH-1:0]      w_wr;
    logic [N_CH-1:0]      w_tick;
    logic [N_CH-1:0]      w_clk;
    logic [SCAN_BITS-1:0] r_scan;

    // Selects at or beyond N_CH match no channel, so such writes drop out.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign w_wr[i] = div_wr && (div_sel == SEL_W'(i));

        clk_div_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (en[i]),
            .wr      (w_wr[i]),
            .val     (div_val),
            .tick    (w_tick[i]),
            .clk_out (w_clk[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan <= '0;
        end else if (w_tick[SCAN_CH]) begin
            r_scan <= r_scan + SCAN_BITS'(1);
        end
    end

    assign tick     = w_tick;
    assign clk_out  = w_clk;
    assign scan_ctl = r_scan;

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank against a period-based reference model.
module tb_clk_div_bank;
    import clk_div_pkg::*;

    localparam int unsigned NCH = 5;
    localparam int unsigned CW  = 4;
    localparam int unsigned SB  = 2;
    localparam int unsigned SCH = 0;
    localparam int unsigned SW  = sel_w(NCH);
    localparam int          DEF = 15;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] en;
    logic           div_wr;
    logic [SW-1:0]  div_sel;
    logic [CW-1:0]  div_val;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] clk_out;
    logic [SB-1:0]  scan_ctl;

    int errors = 0;
    int checks = 0;
    logic [NCH-1:0] cur_en;

    // Reference model: divisor, pending divisor, edges since last tick.
    int m_act  [NCH];
    int m_pend [NCH];
    int m_age  [NCH];
    bit m_pv   [NCH];
    bit m_tick [NCH];
    bit m_clk  [NCH];
    int m_scan;

    clk_div_bank #(
        .N_CH        (NCH),
        .CNT_W       (CW),
        .SCAN_BITS   (SB),
        .SCAN_CH     (SCH),
        .DEFAULT_DIV (4'd15)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_wr   (div_wr),
        .div_sel  (div_sel),
        .div_val  (div_val),
        .tick     (tick),
        .clk_out  (clk_out),
        .scan_ctl (scan_ctl)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (errors=%0d)", errors);
        $fatal(1);
    end

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_act[c] = DEF; m_pend[c] = 0; m_pv[c] = 0;
            m_age[c] = 0; m_tick[c] = 0; m_clk[c] = 0;
        end
        m_scan = 0;
    endtask

    task automatic model_edge(input logic [NCH-1:0] e, input bit w, input int s, input int v);
        bit hit;
        int per;
        if (m_tick[SCH]) m_scan = (m_scan + 1) % (1 << SB);
        for (int c = 0; c < NCH; c++) begin
            hit = w && (s == c);
            if (!e[c]) begin
                m_age[c] = 0; m_tick[c] = 0; m_clk[c] = 0;
                if (hit) begin
                    m_act[c] = v; m_pend[c] = v; m_pv[c] = 0;
                end else if (m_pv[c]) begin
                    m_act[c] = m_pend[c]; m_pv[c] = 0;
                end
            end else begin
                per = (m_act[c] == 0) ? 1 : m_act[c];
                if (m_age[c] + 1 >= per) begin
                    m_age[c] = 0; m_tick[c] = 1; m_clk[c] = !m_clk[c];
                    if (hit) begin
                        m_act[c] = v; m_pv[c] = 0;
                    end else if (m_pv[c]) begin
                        m_act[c] = m_pend[c]; m_pv[c] = 0;
                    end
                end else begin
                    m_age[c] = m_age[c] + 1; m_tick[c] = 0;
                    if (hit) begin
                        m_pend[c] = v; m_pv[c] = 1;
                    end
                end
            end
        end
    endtask

    function automatic logic [NCH-1:0] exp_tick();
        logic [NCH-1:0] r;
        for (int c = 0; c < NCH; c++) r[c] = m_tick[c];
        return r;
    endfunction

    function automatic logic [NCH-1:0] exp_clk();
        logic [NCH-1:0] r;
        for (int c = 0; c < NCH; c++) r[c] = m_clk[c];
        return r;
    endfunction

    // One clock edge with the given write; returns at posedge+1.
    task automatic cyc(input bit w, input int s, input int v);
        en      = cur_en;
        div_wr  = w;
        div_sel = SW'(s);
        div_val = CW'(v);
        @(posedge clk);
        model_edge(cur_en, w, s, v);
        #1;
        div_wr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cur_en = '0; en = '0; div_wr = 1'b0; div_sel = '0; div_val = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (tick !== '0) $display("FAIL reset_tick: got %b want %b", tick, {NCH{1'b0}});
        checks++; if (clk_out !== '0) $display("FAIL reset_clk: got %b want %b", clk_out, {NCH{1'b0}});
        checks++; if (scan_ctl !== '0) $display("FAIL reset_scan: got %0d want 0", scan_ctl);
        if (tick !== '0) errors++;
        if (clk_out !== '0) errors++;
        if (scan_ctl !== '0) errors++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int tq[$];
        int want[4] = '{15, 30, 45, 60};
        logic ec;
        cur_en = 5'b00001;
        for (int r = 1; r <= 61; r++) begin
            cyc(0, 0, 0);
            checks++;
            if (tick !== exp_tick()) begin errors++; $display("FAIL basic_tick r=%0d: got %b want %b", r, tick, exp_tick()); end
            checks++;
            if (scan_ctl !== SB'(m_scan)) begin errors++; $display("FAIL basic_scan r=%0d: got %0d want %0d", r, scan_ctl, m_scan); end
            ec = ((r / 15) % 2) == 1;
            checks++;
            if (clk_out[0] !== ec) begin errors++; $display("FAIL basic_clk0 r=%0d: got %b want %b", r, clk_out[0], ec); end
            if (r == 16 || r == 31 || r == 46 || r == 61) begin
                checks++;
                if (scan_ctl !== SB'((r / 15) % 4)) begin
                    errors++; $display("FAIL basic_scan_seq r=%0d: got %0d want %0d", r, scan_ctl, (r / 15) % 4);
                end
            end
            if (tick[0]) tq.push_back(r);
        end
        checks++;
        if (tq.size() != 4 || tq[0] != want[0] || tq[1] != want[1] || tq[2] != want[2] || tq[3] != want[3]) begin
            errors++; $display("FAIL basic_tick_edges: got %0d ticks first=%0d want 4 ticks at 15,30,45,60",
                               tq.size(), (tq.size() > 0) ? tq[0] : -1);
        end
    endtask

    task automatic test_reload();
        int tq[$];
        cyc(1, 1, 6);
        cur_en[1] = 1'b1;
        for (int r = 1; r <= 18; r++) begin
            cyc(r == 8, 1, 3);
            checks++;
            if (tick !== exp_tick() || clk_out !== exp_clk()) begin
                errors++; $display("FAIL reload_state r=%0d: got %b/%b want %b/%b", r, tick, clk_out, exp_tick(), exp_clk());
            end
            if (tick[1]) tq.push_back(r);
        end
        checks++;
        if (tq.size() != 4 || tq[0] != 6 || tq[1] != 12 || tq[2] != 15 || tq[3] != 18) begin
            errors++; $display("FAIL reload_edges: got %0d ticks, want edges 6,12,15,18", tq.size());
        end
    endtask

    task automatic test_wrap_write();
        int tq[$];
        cur_en[1] = 1'b0;
        cyc(1, 1, 5);
        cur_en[1] = 1'b1;
        for (int r = 1; r <= 9; r++) begin
            cyc(r == 5, 1, 2);
            checks++;
            if (dut.g_ch[1].u_chan.r_pv !== 1'b0) begin
                errors++; $display("FAIL wrap_pv r=%0d: got %b want 0", r, dut.g_ch[1].u_chan.r_pv);
            end
            checks++;
            if (tick !== exp_tick()) begin errors++; $display("FAIL wrap_tick r=%0d: got %b want %b", r, tick, exp_tick()); end
            if (tick[1]) tq.push_back(r);
        end
        checks++;
        if (tq.size() != 3 || tq[0] != 5 || tq[1] != 7 || tq[2] != 9) begin
            errors++; $display("FAIL wrap_edges: got %0d ticks, want edges 5,7,9", tq.size());
        end
    endtask

    task automatic test_small_div();
        logic ec;
        cyc(1, 2, 0);
        cur_en[2] = 1'b1;
        for (int r = 1; r <= 10; r++) begin
            cyc(r == 4, 2, 1);
            ec = (r % 2) == 1;
            checks++;
            if (tick[2] !== 1'b1) begin errors++; $display("FAIL small_tick r=%0d: got %b want 1", r, tick[2]); end
            checks++;
            if (clk_out[2] !== ec) begin errors++; $display("FAIL small_clk r=%0d: got %b want %b", r, clk_out[2], ec); end
            checks++;
            if (tick !== exp_tick()) begin errors++; $display("FAIL small_model r=%0d: got %b want %b", r, tick, exp_tick()); end
        end
    endtask

    task automatic test_disable();
        int tq[$];
        cur_en[3] = 1'b1;
        repeat (20) cyc(0, 0, 0);
        checks++;
        if (clk_out[3] !== 1'b1) begin errors++; $display("FAIL dis_pre_clk: got %b want 1", clk_out[3]); end
        cur_en[3] = 1'b0;
        for (int r = 1; r <= 3; r++) begin
            cyc(r == 2, 3, 4);
            checks++;
            if (tick[3] !== 1'b0 || clk_out[3] !== 1'b0 || dut.g_ch[3].u_chan.r_cnt !== '0) begin
                errors++; $display("FAIL dis_idle r=%0d: got tick=%b clk=%b cnt=%0d want 0/0/0",
                                   r, tick[3], clk_out[3], dut.g_ch[3].u_chan.r_cnt);
            end
        end
        cur_en[3] = 1'b1;
        for (int r = 1; r <= 8; r++) begin
            cyc(0, 0, 0);
            checks++;
            if (tick !== exp_tick() || clk_out !== exp_clk()) begin
                errors++; $display("FAIL dis_model r=%0d: got %b/%b want %b/%b", r, tick, clk_out, exp_tick(), exp_clk());
            end
            if (tick[3]) tq.push_back(r);
        end
        checks++;
        if (tq.size() != 2 || tq[0] != 4 || tq[1] != 8) begin
            errors++; $display("FAIL dis_edges: got %0d ticks, want edges 4,8", tq.size());
        end
    endtask

    task automatic test_async_reset();
        logic [NCH-1:0] et;
        cur_en = '1;
        for (int r = 1; r <= 7; r++) begin
            cyc(0, 0, 0);
            checks++;
            if (tick !== exp_tick()) begin errors++; $display("FAIL arst_pre r=%0d: got %b want %b", r, tick, exp_tick()); end
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (tick !== '0 || clk_out !== '0 || scan_ctl !== '0) begin
            errors++; $display("FAIL arst_clear: got tick=%b clk=%b scan=%0d want all 0", tick, clk_out, scan_ctl);
        end
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int r = 1; r <= 15; r++) begin
            cyc(r == 1, NCH, 3);
            et = (r == 15) ? '1 : '0;
            checks++;
            if (tick !== et) begin errors++; $display("FAIL arst_tick r=%0d: got %b want %b", r, tick, et); end
            checks++;
            if (clk_out !== exp_clk()) begin errors++; $display("FAIL arst_clk r=%0d: got %b want %b", r, clk_out, exp_clk()); end
        end
    endtask

    task automatic test_random();
        bit w;
        int s;
        int v;
        for (int r = 1; r <= 400; r++) begin
            if ($urandom_range(0, 7) == 0) cur_en[$urandom_range(0, NCH - 1)] ^= 1'b1;
            w = ($urandom_range(0, 3) == 0);
            s = $urandom_range(0, 7);
            v = $urandom_range(0, 15);
            cyc(w, s, v);
            checks++;
            if (tick !== exp_tick()) begin errors++; $display("FAIL rand_tick r=%0d: got %b want %b", r, tick, exp_tick()); end
            checks++;
            if (clk_out !== exp_clk()) begin errors++; $display("FAIL rand_clk r=%0d: got %b want %b", r, clk_out, exp_clk()); end
            checks++;
            if (scan_ctl !== SB'(m_scan)) begin errors++; $display("FAIL rand_scan r=%0d: got %0d want %0d", r, scan_ctl, m_scan); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reload();
        test_wrap_write();
        test_small_div();
        test_disable();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
